// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {ARB_CORE, ARB_HOST} arb_state_t;

  localparam int DEF_AW       = 8;
  localparam int DEF_DW       = 8;
  localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Core-favoured two-port arbiter for dat_mem; a bounded wait counter
// guarantees the host a grant even under back-to-back core traffic.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out,
  output logic [7:0]    conflict_cnt
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW:0] MAX_W = MAX_WAIT[WCW:0];

  arb_state_t    state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [WCW:0]   wait_inc;
  logic [DW-1:0]  host_rdata_q, host_rdata_d;
  logic           host_rvalid_q, host_rvalid_d;
  logic [7:0]     conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    host_rdata_d   = host_rdata_q;
    host_rvalid_d  = 1'b0;
    mem_addr       = core_addr;
    mem_dat_in     = core_wdata;
    mem_wr_en      = 1'b0;
    core_rdata     = '0;
    core_stall     = 1'b0;
    host_gnt       = 1'b0;
    wait_inc       = {1'b0, wait_cnt_q} + {{WCW{1'b0}}, 1'b1};

    case (state_q)
      ARB_CORE: begin
        mem_wr_en  = core_req & core_we;
        core_rdata = mem_dat_out;
        if (!host_req) begin
          wait_cnt_d = '0;
        end else if (!core_req || wait_inc == MAX_W) begin
          state_d    = ARB_HOST;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_inc[WCW-1:0];
        end
      end
      ARB_HOST: begin
        host_gnt   = 1'b1;
        mem_addr   = host_addr;
        mem_dat_in = host_wdata;
        mem_wr_en  = host_req & host_we;
        core_stall = core_req;
        if (host_req && !host_we) begin
          host_rdata_d  = mem_dat_out;
          host_rvalid_d = 1'b1;
        end
        if (!(host_req && host_lock)) state_d = ARB_HOST == state_d ? ARB_CORE : state_d;
      end
      default: state_d = ARB_CORE;
    endcase

    // Reset masks side effects even if the state register still says ARB_HOST.
    if (reset) begin
      mem_wr_en  = 1'b0;
      core_stall = 1'b0;
      host_gnt   = 1'b0;
    end

    conflict_cnt_d = (core_stall && conflict_cnt_q != 8'hFF) ? conflict_cnt_q + 8'd1
                                                             : conflict_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ARB_CORE;
      wait_cnt_q     <= '0;
      host_rdata_q   <= '0;
      host_rvalid_q  <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      host_rdata_q   <= host_rdata_d;
      host_rvalid_q  <= host_rvalid_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign host_rdata   = host_rdata_q;
  assign host_rvalid  = host_rvalid_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus reset and
// saturation sequences, with a behavioural dat_mem preloaded to addr+0x80.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, host_req, host_we, host_lock;
  logic [AW-1:0] core_addr, host_addr, mem_addr;
  logic [DW-1:0] core_wdata, host_wdata, core_rdata, host_rdata, mem_dat_in, mem_dat_out;
  logic          core_stall, host_gnt, host_rvalid, mem_wr_en;
  logic [7:0]    conflict_cnt;

  logic [DW-1:0] tb_mem [256];
  logic          mem_init;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_dat_in(mem_dat_in),
    .mem_dat_out(mem_dat_out), .conflict_cnt(conflict_cnt)
  );

  assign mem_dat_out = tb_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 8'(i + 8'h80);
    end else if (mem_wr_en) begin
      tb_mem[mem_addr] <= mem_dat_in;
    end
  end

  typedef struct {
    logic       rst, creq, cwe;
    logic [7:0] caddr, cwd;
    logic       hreq, hwe;
    logic [7:0] haddr, hwd;
    logic       hlock;
    logic       e_stall, e_gnt, e_wr;
    logic [7:0] e_crd;
    logic       e_rv;
    logic [7:0] e_rd, e_cnt;
  } vec_t;

  vec_t vt [22];

  function automatic vec_t mk(
    input logic rst, creq, cwe, input logic [7:0] caddr, cwd,
    input logic hreq, hwe, input logic [7:0] haddr, hwd, input logic hlock,
    input logic e_stall, e_gnt, e_wr, input logic [7:0] e_crd,
    input logic e_rv, input logic [7:0] e_rd, e_cnt);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd; v.hlock = hlock;
    v.e_stall = e_stall; v.e_gnt = e_gnt; v.e_wr = e_wr; v.e_crd = e_crd;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, creq, cwe, input logic [7:0] caddr, cwd,
                       input logic hreq, hwe, input logic [7:0] haddr, hwd,
                       input logic hlock);
    reset = rst; core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd; host_lock = hlock;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_init = 1'b1;
    drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);

    // rst creq cwe caddr cwd | hreq hwe haddr hwd hlock || stall gnt wr crd rv rd cnt
    vt[0]  = mk(1,1,1,8'h10,8'h11, 1,1,8'h20,8'h99,0, 0,0,0,8'h90, 0,8'h00,8'd0);
    vt[1]  = mk(0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h80, 0,8'h00,8'd0);
    vt[2]  = mk(0,1,1,8'h10,8'h5A, 0,0,8'h00,8'h00,0, 0,0,1,8'h90, 0,8'h00,8'd0);
    vt[3]  = mk(0,1,0,8'h10,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h5A, 0,8'h00,8'd0);
    vt[4]  = mk(0,0,0,8'h00,8'h00, 1,1,8'h20,8'hC3,0, 0,0,0,8'h80, 0,8'h00,8'd0);
    vt[5]  = mk(0,0,0,8'h00,8'h00, 1,1,8'h20,8'hC3,0, 0,1,1,8'h00, 0,8'h00,8'd0);
    vt[6]  = mk(0,0,0,8'h00,8'h00, 1,0,8'h20,8'h00,0, 0,0,0,8'h80, 0,8'h00,8'd0);
    vt[7]  = mk(0,0,0,8'h00,8'h00, 1,0,8'h20,8'h00,0, 0,1,0,8'h00, 0,8'h00,8'd0);
    vt[8]  = mk(0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h80, 1,8'hC3,8'd0);
    vt[9]  = mk(0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h80, 0,8'hC3,8'd0);
    vt[10] = mk(0,1,0,8'h05,8'h00, 1,0,8'h03,8'h00,0, 0,0,0,8'h85, 0,8'hC3,8'd0);
    vt[11] = mk(0,1,0,8'h05,8'h00, 1,0,8'h03,8'h00,0, 0,0,0,8'h85, 0,8'hC3,8'd0);
    vt[12] = mk(0,1,0,8'h05,8'h00, 1,0,8'h03,8'h00,0, 0,0,0,8'h85, 0,8'hC3,8'd0);
    vt[13] = mk(0,1,0,8'h05,8'h00, 1,0,8'h03,8'h00,0, 0,0,0,8'h85, 0,8'hC3,8'd0);
    vt[14] = mk(0,1,0,8'h05,8'h00, 1,0,8'h03,8'h00,0, 1,1,0,8'h00, 0,8'hC3,8'd0);
    vt[15] = mk(0,1,0,8'h05,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h85, 1,8'h83,8'd1);
    vt[16] = mk(0,0,0,8'h05,8'h00, 1,0,8'h00,8'h00,1, 0,0,0,8'h85, 0,8'h83,8'd1);
    vt[17] = mk(0,1,0,8'h05,8'h00, 1,0,8'h00,8'h00,1, 1,1,0,8'h00, 0,8'h83,8'd1);
    vt[18] = mk(0,1,0,8'h05,8'h00, 1,0,8'h01,8'h00,1, 1,1,0,8'h00, 1,8'h80,8'd2);
    vt[19] = mk(0,1,0,8'h05,8'h00, 1,0,8'h02,8'h00,0, 1,1,0,8'h00, 1,8'h81,8'd3);
    vt[20] = mk(0,1,0,8'h05,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h85, 1,8'h82,8'd4);
    vt[21] = mk(0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0, 0,0,0,8'h80, 0,8'h82,8'd4);

    step();
    step();
    mem_init = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vt[i].rst, vt[i].creq, vt[i].cwe, vt[i].caddr, vt[i].cwd,
            vt[i].hreq, vt[i].hwe, vt[i].haddr, vt[i].hwd, vt[i].hlock);
      #1;
      chk($sformatf("v%0d core_stall", i), 32'(core_stall), 32'(vt[i].e_stall));
      chk($sformatf("v%0d host_gnt", i), 32'(host_gnt), 32'(vt[i].e_gnt));
      chk($sformatf("v%0d mem_wr_en", i), 32'(mem_wr_en), 32'(vt[i].e_wr));
      chk($sformatf("v%0d core_rdata", i), 32'(core_rdata), 32'(vt[i].e_crd));
      chk($sformatf("v%0d host_rvalid", i), 32'(host_rvalid), 32'(vt[i].e_rv));
      chk($sformatf("v%0d host_rdata", i), 32'(host_rdata), 32'(vt[i].e_rd));
      chk($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt), 32'(vt[i].e_cnt));
      step();
    end

    // Reset arriving mid-burst with a write pending.
    drive(0, 0, 0, 8'h05, 8'h00, 1, 0, 8'h00, 8'h00, 1);
    #1 chk("rst_a host_gnt", 32'(host_gnt), 32'd0);
    step();
    #1 chk("rst_b host_gnt", 32'(host_gnt), 32'd1);
    step();
    drive(1, 1, 1, 8'h05, 8'h11, 1, 1, 8'h30, 8'h77, 1);
    #1;
    chk("rst_c mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_c host_gnt", 32'(host_gnt), 32'd0);
    chk("rst_c core_stall", 32'(core_stall), 32'd0);
    chk("rst_c host_rvalid", 32'(host_rvalid), 32'd1);
    chk("rst_c host_rdata", 32'(host_rdata), 32'h80);
    step();
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    #1;
    chk("rst_d host_gnt", 32'(host_gnt), 32'd0);
    chk("rst_d host_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_d host_rdata", 32'(host_rdata), 32'd0);
    chk("rst_d conflict_cnt", 32'(conflict_cnt), 32'd0);
    chk("rst_d mem30 untouched", 32'(tb_mem[8'h30]), 32'hB0);
    chk("rst_d mem05 untouched", 32'(tb_mem[8'h05]), 32'h85);
    step();

    // Locked host burst starving the core to saturate conflict_cnt.
    drive(0, 0, 0, 8'h05, 8'h00, 1, 0, 8'h00, 8'h00, 1);
    step();
    drive(0, 1, 0, 8'h05, 8'h00, 1, 0, 8'h00, 8'h00, 1);
    for (int c = 0; c < 254; c++) step();
    chk("sat core_stall", 32'(core_stall), 32'd1);
    chk("sat cnt 254", 32'(conflict_cnt), 32'd254);
    step();
    chk("sat cnt 255", 32'(conflict_cnt), 32'd255);
    for (int c = 0; c < 45; c++) step();
    chk("sat cnt held", 32'(conflict_cnt), 32'd255);

    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    step();
    step();
    chk("post-burst host_gnt", 32'(host_gnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
